// File: rtl/weight_gen_pkg.sv
// Shared definitions for the pattern-based weight/activation generators.
//   - Pattern mode select values.
//   - 16-bit Fibonacci LFSR taps, default seed and single-step function.
//   - Streamer FSM state encoding.
package weight_gen_pkg;

  localparam logic [1:0] MODE_ZEROS = 2'd0;
  localparam logic [1:0] MODE_ONES  = 2'd1;
  localparam logic [1:0] MODE_RAMP  = 2'd2;
  localparam logic [1:0] MODE_LFSR  = 2'd3;

  localparam int unsigned LFSR_TAP_A = 15;
  localparam int unsigned LFSR_TAP_B = 13;
  localparam int unsigned LFSR_TAP_C = 12;
  localparam int unsigned LFSR_TAP_D = 10;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } stream_state_e;

  // One Fibonacci step: shift left, feedback into bit 0.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
  endfunction

endpackage

// File: rtl/lfsr16_step.sv
// Registered 16-bit Fibonacci LFSR with synchronous load and step enable.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset (state -> RESET_VAL)
//   load_i    - load seed_i (has priority over enable_i)
//   enable_i  - advance one step
//   seed_i    - value loaded on load_i
//   state_o   - current registered state
module lfsr16_step
  import weight_gen_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        enable_i,
  input  logic [15:0] seed_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (enable_i) begin
      state_d = lfsr16_next(state_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/weight_pattern_stream.sv
// Streams a MATRIX_SIZE x NUM_PE_ROWS weight tile, one row per beat, under
// valid/ready flow control. Patterns: zeros, ones, ramp, LFSR.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   start      - begin a tile (sampled only when idle)
//   mode       - pattern select, latched on accepted start
//   abort      - synchronous cancel, highest priority
//   out_data   - row data, element c at [c*WEIGHT_BW +: WEIGHT_BW] (registered)
//   out_valid  - out_data valid (registered)
//   out_ready  - downstream accepts the current beat
//   beat_idx   - index of the current beat
//   busy       - tile in progress
//   done       - high in the cycle the last beat is accepted
module weight_pattern_stream
  import weight_gen_pkg::*;
#(
  parameter int          WEIGHT_BW   = 8,
  parameter int          NUM_PE_ROWS = 8,
  parameter int          MATRIX_SIZE = 8,
  parameter logic [15:0] LFSR_SEED   = LFSR_DEFAULT_SEED,
  localparam int         BEAT_W      = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1,
  localparam int         ROW_W       = WEIGHT_BW * NUM_PE_ROWS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              abort,
  output logic [ROW_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] beat_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MATRIX_SIZE - 1);
  localparam int LFSR_EXT_W = (WEIGHT_BW > 16) ? WEIGHT_BW : 16;

  stream_state_e     state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              valid_q, valid_d;
  logic [ROW_W-1:0]  data_q, data_d;

  logic [15:0]       lfsr_q;
  logic              lfsr_load;
  logic              lfsr_en;

  logic              accept;
  logic              last;
  logic              done_c;

  // Row generator inputs describe the row that will be shown next cycle.
  logic              row_load;
  logic [1:0]        row_mode;
  logic [BEAT_W-1:0] row_beat;
  logic [15:0]       row_lfsr;
  logic [ROW_W-1:0]  row_d;

  logic [LFSR_EXT_W-1:0] lfsr_ext;
  logic [WEIGHT_BW-1:0]  lfsr_w;

  assign accept = valid_q & out_ready;
  assign last   = (beat_q == LAST_BEAT);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    beat_d    = beat_q;
    valid_d   = valid_q;
    row_load  = 1'b0;
    row_mode  = mode_q;
    row_beat  = beat_q;
    row_lfsr  = lfsr_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    done_c    = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      beat_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_STREAM;
            mode_d    = mode;
            beat_d    = '0;
            valid_d   = 1'b1;
            lfsr_load = 1'b1;
            row_load  = 1'b1;
            row_mode  = mode;
            row_beat  = '0;
            row_lfsr  = LFSR_SEED;
          end
        end
        ST_STREAM: begin
          if (accept) begin
            lfsr_en = (mode_q == MODE_LFSR);
            if (last) begin
              state_d = ST_IDLE;
              valid_d = 1'b0;
              beat_d  = '0;
              done_c  = 1'b1;
            end else begin
              beat_d   = beat_q + 1'b1;
              row_load = 1'b1;
              row_beat = beat_q + 1'b1;
              // Next row must use the post-step LFSR value, not the registered one.
              row_lfsr = lfsr_en ? lfsr16_next(lfsr_q) : lfsr_q;
            end
          end
        end
      endcase
    end
  end

  lfsr16_step #(
    .RESET_VAL (LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load_i   (lfsr_load),
    .enable_i (lfsr_en),
    .seed_i   (LFSR_SEED),
    .state_o  (lfsr_q)
  );

  // Zero-extend for WEIGHT_BW > 16, otherwise take the low bits.
  assign lfsr_ext = LFSR_EXT_W'(row_lfsr);
  assign lfsr_w   = lfsr_ext[WEIGHT_BW-1:0];

  for (genvar c = 0; c < NUM_PE_ROWS; c++) begin : g_row
    logic [WEIGHT_BW-1:0] elem;
    always_comb begin
      elem = '0;
      unique case (row_mode)
        MODE_ZEROS: elem = '0;
        MODE_ONES:  elem = '1;
        MODE_RAMP:  elem = WEIGHT_BW'(32'(row_beat) * 32'(NUM_PE_ROWS) + 32'(c));
        MODE_LFSR:  elem = lfsr_w + WEIGHT_BW'(c);
      endcase
    end
    assign row_d[c*WEIGHT_BW +: WEIGHT_BW] = elem;
  end

  assign data_d = row_load ? row_d : data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ZEROS;
      beat_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign beat_idx  = beat_q;
  assign busy      = (state_q == ST_STREAM);
  // Gated by valid_q, so an asynchronous reset clears it immediately.
  assign done      = done_c;

endmodule

// File: tb/tb_weight_pattern_stream.sv
module tb_weight_pattern_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, out_ready;
  logic [1:0]  mode;
  logic [63:0] out_data;
  logic        out_valid, busy, done;
  logic [2:0]  beat_idx;

  logic         b_start, b_abort, b_ready;
  logic [1:0]   b_mode;
  logic [255:0] b_data;
  logic         b_valid, b_busy, b_done;
  logic [4:0]   b_beat;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  weight_pattern_stream dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .beat_idx(beat_idx), .busy(busy), .done(done)
  );

  weight_pattern_stream #(
    .WEIGHT_BW(8), .NUM_PE_ROWS(32), .MATRIX_SIZE(32)
  ) dut32 (
    .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .abort(b_abort),
    .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready),
    .beat_idx(b_beat), .busy(b_busy), .done(b_done)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: element value from the pattern rules with plain integer math.
  function automatic logic [7:0] model_elem(input int m, input int n, input int b, input int c);
    logic [15:0] s;
    logic        fb;
    int          v;
    v = 0;
    case (m)
      0: v = 0;
      1: v = 255;
      2: v = b * n + c;
      default: begin
        s = 16'hACE1;
        for (int i = 0; i < b; i++) begin
          fb = s[15] ^ s[13] ^ s[12] ^ s[10];
          s  = {s[14:0], fb};
        end
        v = int'(s[7:0]) + c;
      end
    endcase
    return v[7:0];
  endfunction

  function automatic logic [63:0] model_row(input int m, input int b);
    logic [63:0] r;
    for (int c = 0; c < 8; c++) r[c*8 +: 8] = model_elem(m, 8, b, c);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input int m);
    start = 1'b1;
    mode  = 2'(m);
    tick();
    start = 1'b0;
  endtask

  // ready_mode: 0 always ready, 1 random, 2 stall 4 cycles at beat 4.
  task automatic run_stream(input int m, input int ready_mode, input int busy_start_beat,
                            input int abort_beat, input int start_on_done, input int next_mode);
    int exp_b = 0;
    int cyc = 0;
    int stall_left = 4;
    while (exp_b < 8 && cyc < 200) begin
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 9) < 7);
        default: begin
          out_ready = !(exp_b == 4 && stall_left > 0);
          if (!out_ready) stall_left--;
        end
      endcase
      start = 1'b0;
      if (exp_b == busy_start_beat) begin
        start = 1'b1;
        mode  = 2'(m) ^ 2'd3;
      end
      if (start_on_done != 0 && exp_b == 7) begin
        start = 1'b1;
        mode  = 2'(next_mode);
      end
      abort = (exp_b == abort_beat);
      #1;
      check("valid", out_valid, 1);
      check("busy", busy, 1);
      check("beat_idx", beat_idx, exp_b);
      check($sformatf("data m%0d b%0d", m, exp_b), out_data, model_row(m, exp_b));
      check("done", done, (out_ready && exp_b == 7 && !abort));
      if (abort) begin
        tick();
        abort = 1'b0;
        start = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_beat", beat_idx, 0);
        check("abort_done", done, 0);
        return;
      end
      if (out_ready) exp_b++;
      tick();
      cyc++;
    end
    check("beats_delivered", exp_b, 8);
    if (ready_mode == 0) check("stream_cycles", cyc, 8);
    #1;
    check("end_valid", out_valid, 0);
    check("end_busy", busy, 0);
    if (start_on_done != 0) begin
      tick();
      start = 1'b0;
    end else begin
      check("end_done", done, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; mode = 2'd0;
    b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b0; b_mode = 2'd0;
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_beat", beat_idx, 0);
    check("rst_data", out_data, 0);
    check("rst_b_valid", b_valid, 0);
    #4;
    rst = 1'b0;
    tick();

    // Idle: no start, nothing streams.
    check("idle_valid", out_valid, 0);

    do_start(1); run_stream(1, 0, -1, -1, 0, 0);
    do_start(2); run_stream(2, 0, -1, -1, 0, 0);
    do_start(3); run_stream(3, 0, -1, -1, 0, 0);
    do_start(2); run_stream(2, 2, -1, -1, 0, 0);

    // Asynchronous reset at beat 3, then restart from beat 0.
    do_start(2);
    out_ready = 1'b1;
    repeat (3) tick();
    #1;
    check("pre_rst_beat", beat_idx, 3);
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_beat", beat_idx, 0);
    rst = 1'b0;
    tick();
    // Start held through the done cycle is ignored there, accepted the cycle after.
    do_start(2); run_stream(2, 0, -1, -1, 1, 3);
    run_stream(3, 0, -1, -1, 0, 0);

    // Mid-stream start ignored, abort at beat 5, then reseeded restart.
    do_start(3); run_stream(3, 0, 2, 5, 0, 0);
    tick();
    check("post_abort_idle", out_valid, 0);
    do_start(3); run_stream(3, 1, -1, -1, 0, 0);

    for (int k = 0; k < 4; k++) begin
      int m;
      m = int'($urandom_range(0, 3));
      do_start(m); run_stream(m, 1, -1, -1, 0, 0);
    end

    // Large tile: 32 beats x 32 elements, ramp.
    b_start = 1'b1; b_mode = 2'd2; b_ready = 1'b1;
    tick();
    b_start = 1'b0;
    for (int b = 0; b < 32; b++) begin
      logic [255:0] er;
      #1;
      for (int c = 0; c < 32; c++) er[c*8 +: 8] = model_elem(2, 32, b, c);
      check("big_valid", b_valid, 1);
      check("big_beat", b_beat, b);
      check($sformatf("big_data b%0d", b), b_data, er);
      check("big_done", b_done, (b == 31));
      if (b == 31) check("big_b31_e31", b_data[255:248], 8'hFF);
      tick();
    end
    #1;
    check("big_end_valid", b_valid, 0);
    check("big_end_busy", b_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_pattern_stream.md
Name: weight_pattern_stream

Overview:
- Parametrised successor to the static all-0/all-1 weight source.
- Streams a full MATRIX_SIZE x NUM_PE_ROWS weight tile, one row per beat, into the weight FIFO / systolic-array loader under valid/ready flow control.
- Selectable pattern modes: zeros, ones, ramp, LFSR. Used for bring-up and regression in place of real SRAM-fed weights.

Parameters:
- WEIGHT_BW, 8, bits per weight element
- NUM_PE_ROWS, 8, elements per beat (one per PE row)
- MATRIX_SIZE, 8, beats per tile
- LFSR_SEED, 16'hACE1, LFSR state loaded on every start

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- start  input  1  begin tile; sampled only in IDLE
- mode  input  2  pattern select, latched on accepted start
- abort  input  1  synchronous cancel; returns to IDLE
- out_data  output  WEIGHT_BW*NUM_PE_ROWS  row data; element c at bits [c*WEIGHT_BW +: WEIGHT_BW]
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts beat
- beat_idx  output  clog2(MATRIX_SIZE) (min 1)  index of current beat
- busy  output  1  high from accepted start until tile completes or abort
- done  output  1  one-cycle pulse on acceptance of the last beat

Behaviour:
- Reset (async, rst=1): state IDLE; out_data=0, out_valid=0, beat_idx=0, busy=0, done=0; LFSR=LFSR_SEED; latched mode=0.
- FSM states: IDLE, STREAM.
- IDLE: on start=1 (and abort=0), latch mode, load LFSR=LFSR_SEED, beat_idx=0, go to STREAM. In the next cycle, out_valid=1, busy=1, and out_data holds beat 0. Start-to-first-valid latency is 1 cycle.
- STREAM, beat accepted (out_valid & out_ready):
  - If beat_idx==MATRIX_SIZE-1: out_valid=0, busy=0, done=1 for one cycle, return to IDLE.
  - Otherwise: beat_idx+1, out_data gets the next row in the same cycle, out_valid stays 1. Back-to-back beats run at 1 beat/cycle.
- STREAM, out_valid & !out_ready: out_data, beat_idx and LFSR all hold stable. No bubbles or drops.
- start while busy: ignored, no effect on mode or stream.
- start in the same cycle as the done pulse: ignored. A new start is accepted in IDLE from the following cycle.
- abort=1 (any state, priority over start and handshake): next cycle state=IDLE, out_valid=0, busy=0, beat_idx=0, done=0.
- Pattern per beat b, element c; all arithmetic is modulo 2^WEIGHT_BW, truncate high bits:
  - mode 0 ZEROS: 0
  - mode 1 ONES: all bits 1
  - mode 2 RAMP: b*NUM_PE_ROWS + c
  - mode 3 LFSR: lfsr[WEIGHT_BW-1:0] + c, where lfsr is the state for beat b. For WEIGHT_BW>16, zero-extend lfsr.
- LFSR: 16-bit Fibonacci, fb = s[15]^s[13]^s[12]^s[10], next = {s[14:0], fb}.
  - Advances once per accepted beat, in mode 3 only.
  - Beat 0 uses the seed.
  - Never enters all-zero from a nonzero seed. LFSR_SEED=0 is illegal.
- out_data is driven from registers (no combinational path from out_ready to out_data). out_valid does not depend combinationally on out_ready.

Decomposition:
- Shared package weight_gen_pkg holds:
  - mode constants MODE_ZEROS=0, MODE_ONES=1, MODE_RAMP=2, MODE_LFSR=3
  - LFSR tap positions and default seed
  - FSM state encoding
- One sub-module: lfsr16_step. Inputs: state, enable, load, seed. Output: registered 16-bit state. Shared with future activation pattern generators.
- Row formation is a generate loop inside the top. No further sub-modules.

Test Plan (defaults unless stated):
- Reset mid-stream (beat 3, out_valid=1): assert rst asynchronously -> out_valid, busy, done and beat_idx drop to 0 without a clock edge; the next start begins again at beat 0.
- Mode 1, out_ready held 1: start at cycle 0 -> out_valid=1 cycles 1-8; each out_data = all 64 bits 1; beat_idx 0..7; done=1 only at cycle 8; busy=0 at cycle 9.
- Mode 2, out_ready held 1 -> beat 2, element 3 = 8'h13; beat 7, element 7 = 8'h3F. Repeat with MATRIX_SIZE=32, NUM_PE_ROWS=32: beat 31, element 31 = 1023 mod 256 = 8'hFF.
- Mode 3 -> beat 0, element 0 = 8'hE1 and element 2 = 8'hE3. Beat 1 (LFSR=16'h59C3): element 0 = 8'hC3.
- Backpressure in mode 2: out_ready low for 4 cycles during beat 4 -> out_data and beat_idx stable; all 8 beats delivered exactly once, in order.
- Start while busy, and abort at beat 5 -> mid-stream start is ignored (mode unchanged). Abort: next cycle out_valid=0, busy=0, no done pulse. A fresh start then restarts from beat 0 with the LFSR reseeded.
